perf_counter_bank: RTL
======================

// Module: perf_counter_bank
// PURPOSE
// - Parametrised performance-monitor bank beside the pipeline core: cycle counter, retired-instruction
//   counter (stall/flush aware) and NUM_EVT generic event counters.
// - Live counters are copied atomically into shadow registers on request. A registered read port
//   returns shadow values to the debug/test harness.
// PARAMETERS
// - NUM_EVT  4   number of generic event counters (1..16)
// - CNT_W    32  width of every counter, live and shadow (8..64)
// - ADDR_W   5   read-address width; must satisfy 2**ADDR_W >= NUM_EVT+2
// PORTS
// - clk       in   1        clock
// - rst       in   1        reset, synchronous, active-high
// - cnt_en    in   1        global count enable (0 = freeze all live counters)
// - clr       in   1        clear live counters and overflow flags
// - snap      in   1        copy live counters/flags into shadow registers
// - stall     in   1        pipeline stall (1 = stalled)
// - flush     in   1        pipeline flush (1 = fetched instruction squashed)
// - if_inst   in   32       fetch-stage instruction word; 32'h0 = bubble
// - evt       in   NUM_EVT  per-cycle event pulses, one per generic counter
// - rd_req    in   1        read request
// - rd_addr   in   ADDR_W   0 = cycle, 1 = inst, 2..NUM_EVT+1 = evt[addr-2]
// - rd_valid  out  1        rd_data/rd_ovf valid, one cycle after rd_req
// - rd_data   out  CNT_W    shadow counter value
// - rd_ovf    out  1        shadow overflow flag of the addressed counter
// BEHAVIOUR
// - Reset (rst=1 at posedge): all live/shadow counters, overflow flags, rd_valid, rd_data, rd_ovf = 0.
// - Update priority per posedge: rst > clr > counting. clr zeroes live counters and flags only.
// - Shadows are not cleared by clr.
// - Counting applies only when cnt_en=1; otherwise live values hold.
// - Cycle counter: +1 every enabled cycle.
// - Inst counter, in priority order:
//   - stall=1: hold.
//   - else flush=1: -1, floored at 0 (no underflow wrap).
//   - else if_inst!=0: +1.
//   - else hold.
// - Event counter i: +1 when evt[i]=1. Events are independent; any subset may fire per cycle.
// - Increment at all-ones: wraps to 0 and sets that counter's sticky ovf flag.
// - The ovf flag stays set until clr or rst. Decrement never sets ovf.
// - snap=1: shadows take the live values present before this edge's update. This holds when clr
//   or counting occurs in the same cycle. Shadow ovf flags are captured likewise.
// - Read:
//   - rd_req=1 in cycle N: rd_valid=1 in N+1, with rd_data/rd_ovf from shadows as of the end of N.
//     A snap in cycle N is therefore not visible until a read issued in N+1.
//   - rd_req=0: rd_valid=0 next cycle; rd_data/rd_ovf hold.
//   - Back-to-back reads are allowed, one per cycle.
//   - rd_addr >= NUM_EVT+2: rd_valid=1, rd_data=0, rd_ovf=0.
// - rst asserted mid-read: rd_valid=0 on the next edge; the pending read is dropped.
// CONFIGURATION
// - PERF_SATURATE_EN defined: increments at all-ones saturate (hold all-ones) and still set sticky
//   ovf. The inst decrement from all-ones is allowed.
// - PERF_SATURATE_EN undefined: wrap-to-0 behaviour as above.
// TESTING
// - rst 2 cycles, then cnt_en=1, 10 cycles, snap, read addr 0 -> rd_valid next cycle;
//   rd_data=10 at the snap edge, rd_ovf=0.
// - if_inst=32'h1 x5, then flush x2, then stall+flush x3 -> inst=3.
// - inst=0, then flush=1 x2 -> inst stays 0.
// - CNT_W=8, evt[0]=1 for 256 cycles -> counter=0, ovf=1.
//   With PERF_SATURATE_EN -> counter=8'hFF, ovf=1. A following clr -> 0, ovf=0.
// - clr+snap in same cycle with cycle=42 -> read addr 0 returns 42; live cycle restarts from 0.
// - rd_addr=NUM_EVT+2 -> rd_data=0, rd_ovf=0, rd_valid=1.
//   cnt_en=0 for 5 cycles with evt all-ones -> no live counter changes.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance-monitor bank: cycle, retired-instruction and NUM_EVT event counters with snapshot shadows.
// Build option: define PERF_SATURATE_EN to make increments saturate at all-ones instead of wrapping.
module perf_counter_bank #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt_en_i,
    input  logic               clr_i,
    input  logic               snap_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [31:0]        if_inst_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               rd_req_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_ovf_o
);

    // Counter index map: 0 = cycle, 1 = inst, 2.. = generic events.
    localparam int NC = NUM_EVT + 2;

    logic [CNT_W-1:0] live_q [NC];
    logic [CNT_W-1:0] live_d [NC];
    logic [CNT_W-1:0] shad_q [NC];
    logic [NC-1:0]    ovf_q;
    logic [NC-1:0]    ovf_d;
    logic [NC-1:0]    shad_ovf_q;

    logic [CNT_W:0]   bump_v [NC];
    logic [NC-1:0]    inc_en;
    logic             inst_inc;
    logic             inst_dec;

    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_ovf_q;
    logic [CNT_W-1:0] rd_sel_data;
    logic             rd_sel_ovf;

    // Returns {overflow_hit, next_value} for a single increment.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
        if (&v) begin
`ifdef PERF_SATURATE_EN
            return {1'b1, v};
`else
            return {1'b1, {CNT_W{1'b0}}};
`endif
        end
        return {1'b0, v + CNT_W'(1)};
    endfunction

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            bump_v[i] = bump(live_q[i]);
        end
    end

    assign inst_inc = !stall_i && !flush_i && (if_inst_i != 32'h0);
    assign inst_dec = !stall_i && flush_i && (live_q[1] != '0);
    assign inc_en   = {evt_i, inst_inc, 1'b1};

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            live_d[i] = live_q[i];
        end
        ovf_d = ovf_q;
        if (clr_i) begin
            for (int i = 0; i < NC; i++) begin
                live_d[i] = '0;
            end
            ovf_d = '0;
        end else if (cnt_en_i) begin
            for (int i = 0; i < NC; i++) begin
                if (inc_en[i]) begin
                    live_d[i] = bump_v[i][CNT_W-1:0];
                    ovf_d[i]  = ovf_q[i] | bump_v[i][CNT_W];
                end
            end
            // Flush floors at zero and never touches the overflow flag.
            if (inst_dec) begin
                live_d[1] = live_q[1] - CNT_W'(1);
            end
        end
    end

    // Out-of-range addresses fall through to zero data and flag.
    always_comb begin
        rd_sel_data = '0;
        rd_sel_ovf  = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (rd_addr_i == ADDR_W'(i)) begin
                rd_sel_data = shad_q[i];
                rd_sel_ovf  = shad_ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                live_q[i] <= '0;
                shad_q[i] <= '0;
            end
            ovf_q      <= '0;
            shad_ovf_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NC; i++) begin
                live_q[i] <= live_d[i];
            end
            ovf_q <= ovf_d;
            // Snapshot takes pre-update live values, even alongside clr or counting.
            if (snap_i) begin
                for (int i = 0; i < NC; i++) begin
                    shad_q[i] <= live_q[i];
                end
                shad_ovf_q <= ovf_q;
            end
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_sel_data;
                rd_ovf_q  <= rd_sel_ovf;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_ovf_o   = rd_ovf_q;

endmodule
